apb_fsm_controller: RTL and testbench
=====================================

Name: apb_fsm_controller

Overview:
- APB-side sequencer of the AHB-to-APB bridge; sits between the AHB slave pipeline registers and the three APB peripherals.
- Consumes the AHB slave interface's valid qualifier and its 1- and 2-stage delayed address, data and write registers.
- Generates the APB SETUP/ENABLE phases (Psel, Penable, Pwrite, Paddr, Pwdata) and drives Hreadyout to stall the AHB master while a transfer is in flight.
- Supports back-to-back and pipelined writes, and APB wait states via Pready.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SLV0_BASE, 32'h8000_0000, start of peripheral 0 window (64 MB).
- SLV1_BASE, 32'h8400_0000, start of peripheral 1 window (64 MB).
- SLV2_BASE, 32'h8800_0000, start of peripheral 2 window (64 MB); window ends at 32'h8C00_0000 exclusive.

Ports:
- Hclk  in  1  bridge clock; all logic on its rising edge.
- Hreset  in  1  synchronous active-high reset.
- valid  in  1  current AHB address phase is a legal NONSEQ/SEQ bridge access.
- Hwrite  in  1  current AHB address-phase write flag.
- Hwritereg  in  1  Hwrite delayed 1 cycle.
- Haddr  in  ADDR_W  current AHB address.
- Haddr1  in  ADDR_W  Haddr delayed 1 cycle.
- Haddr2  in  ADDR_W  Haddr delayed 2 cycles.
- Hwdata  in  DATA_W  current AHB write data (data phase).
- Hwdata1  in  DATA_W  Hwdata delayed 1 cycle.
- Pready  in  1  APB completer ready.
- Pselx  out  3  one-hot peripheral select, registered.
- Penable  out  1  APB enable, registered.
- Pwrite  out  1  APB direction, registered.
- Paddr  out  ADDR_W  APB address, registered.
- Pwdata  out  DATA_W  APB write data, registered.
- Hreadyout  out  1  AHB ready back to the master, registered.

Behaviour:
- Interface: one clock, Hclk. Reset is synchronous and active-high on Hreset: when Hreset=1 at a Hclk edge, the block takes its reset values on that edge, regardless of state.
- Reset values: state=ST_IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1.
- Reset mid-transfer: the transfer is abandoned and all outputs take their reset values the same cycle. No completion is signalled.
- Registered outputs: all outputs are computed from next-state and inputs and registered (Moore-style). No combinational path from inputs to outputs.
- Pselx decode: done internally from the address being loaded into Paddr.
  - 001 for [SLV0_BASE, SLV1_BASE).
  - 010 for [SLV1_BASE, SLV2_BASE).
  - 100 for [SLV2_BASE, 32'h8C00_0000).
  - 000 otherwise; the transfer still sequences but no peripheral is selected.
- States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- ST_IDLE:
  - valid & ~Hwrite -> ST_READ: Paddr=Haddr, Pwrite=0, Pselx=dec, Penable=0, Hreadyout=0.
  - valid & Hwrite -> ST_WWAIT: Pselx=0, Penable=0, Hreadyout=1 (collect write data).
  - else stay, outputs idle.
- ST_READ -> ST_RENABLE: Penable=1, Hreadyout=1 (SETUP phase lasts exactly 1 cycle).
- ST_WWAIT: load Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Pselx=dec(Haddr1), Penable=0.
  - ~valid -> ST_WRITE, Hreadyout=1.
  - valid -> ST_WRITEP, Hreadyout=0.
- ST_WRITE -> ~valid ? ST_WENABLE : ST_WENABLEP; Penable=1.
- ST_WRITEP -> ST_WENABLEP; Penable=1.
- Hreadyout on write ENABLE entry: 1 when entering ST_WENABLE; 0 when entering ST_WENABLEP (pending pipelined beat).
- ST_RENABLE / ST_WENABLE with Pready=1: exits identical to ST_IDLE (READ / WWAIT / IDLE) with the same output loads.
  - Completion cycle: Penable=0, Pselx=0 unless going straight to ST_READ.
- ST_WENABLEP with Pready=1:
  - Hwritereg & ~valid -> ST_WRITE, Hreadyout=1.
  - Hwritereg & valid -> ST_WRITEP, Hreadyout=0.
  - In both cases load Paddr=Haddr2, Pwdata=Hwdata1, Pselx=dec(Haddr2), Pwrite=1, Penable=0.
  - ~Hwritereg -> ST_READ: Paddr=Haddr1, Pwrite=0, Pselx=dec(Haddr1), Hreadyout=0.
- Pready=0 in any ENABLE state: hold state and all P* outputs; Hreadyout=0. No limit on wait cycles.
- Simultaneous events:
  - valid is sampled only in ST_IDLE, ST_WWAIT, ST_WRITE and the ENABLE states at Pready=1.
  - In ST_READ and ST_WRITEP, valid is ignored; the master is stalled by Hreadyout=0.
- Latency:
  - Single read: AHB valid -> APB SETUP next cycle -> ENABLE; Hreadyout returns 1 two cycles after valid (zero wait states).
  - Single write: one cycle later than a read (ST_WWAIT).

Test Plan:
- Read 0x8000_0010, Pready=1 -> Pselx=001, Paddr=0x8000_0010, Pwrite=0; Penable 0 then 1; Hreadyout 0,1; back to ST_IDLE.
- Write 0x8400_0004 data 0xDEAD_BEEF, valid then idle -> ST_WWAIT, ST_WRITE, ST_WENABLE; Pselx=010, Pwdata=0xDEAD_BEEF, Pwrite=1.
- Back-to-back writes 0x8800_0000/0x11, 0x8800_0004/0x22 -> second serviced via ST_WRITEP/ST_WENABLEP with Paddr=0x8800_0004, Pwdata=0x22; Hreadyout=0 during pending beat; no data lost.
- Write then read -> ST_WENABLEP -> ST_READ; read Paddr equals second address; Pwrite drops to 0 on the SETUP cycle.
- Pready held 0 for 3 cycles in ST_RENABLE -> Penable, Pselx, Paddr stable; Hreadyout=0 for 3 cycles; completes on Pready=1.
- Hreset=1 asserted during ST_WENABLE -> next edge Pselx=0, Penable=0, Hreadyout=1, ST_IDLE.
- Address 0x8C00_0000 with valid forced 1 -> full sequence with Pselx=000.

Source files
------------

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: turns qualified AHB beats into
// APB SETUP/ENABLE phases and stalls the AHB master through Hreadyout.
module apb_fsm_controller #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [ADDR_W-1:0] SLV2_BASE = 32'h8800_0000
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  input  logic              Pready,
  output logic [2:0]        Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  // Peripheral 2's window is the same size as the others and ends right after it.
  localparam logic [ADDR_W-1:0] SLV2_END = SLV2_BASE + (SLV1_BASE - SLV0_BASE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hreadyout_q, hreadyout_d;
  logic              idle_exit;

  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= SLV0_BASE && addr < SLV1_BASE) begin
      sel = 3'b001;
    end else if (addr >= SLV1_BASE && addr < SLV2_BASE) begin
      sel = 3'b010;
    end else if (addr >= SLV2_BASE && addr < SLV2_END) begin
      sel = 3'b100;
    end
    return sel;
  endfunction

  always_comb begin
    state_d     = state_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    hreadyout_d = hreadyout_q;
    idle_exit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_exit = 1'b1;
      end

      ST_READ: begin
        state_d     = ST_RENABLE;
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
      end

      ST_WWAIT: begin
        paddr_d   = Haddr1;
        pwdata_d  = Hwdata;
        pwrite_d  = 1'b1;
        pselx_d   = decode(Haddr1);
        penable_d = 1'b0;
        if (valid) begin
          state_d     = ST_WRITEP;
          hreadyout_d = 1'b0;
        end else begin
          state_d     = ST_WRITE;
          hreadyout_d = 1'b1;
        end
      end

      ST_WRITE: begin
        penable_d = 1'b1;
        if (valid) begin
          state_d     = ST_WENABLEP;
          hreadyout_d = 1'b0;
        end else begin
          state_d     = ST_WENABLE;
          hreadyout_d = 1'b1;
        end
      end

      ST_WRITEP: begin
        state_d     = ST_WENABLEP;
        penable_d   = 1'b1;
        hreadyout_d = 1'b0;
      end

      ST_RENABLE, ST_WENABLE: begin
        if (Pready) begin
          idle_exit = 1'b1;
        end else begin
          hreadyout_d = 1'b0;
        end
      end

      ST_WENABLEP: begin
        if (Pready) begin
          penable_d = 1'b0;
          // The pending beat is two stages back for a write but one stage back for a read.
          if (Hwritereg) begin
            paddr_d  = Haddr2;
            pwdata_d = Hwdata1;
            pselx_d  = decode(Haddr2);
            pwrite_d = 1'b1;
            if (valid) begin
              state_d     = ST_WRITEP;
              hreadyout_d = 1'b0;
            end else begin
              state_d     = ST_WRITE;
              hreadyout_d = 1'b1;
            end
          end else begin
            state_d     = ST_READ;
            paddr_d     = Haddr1;
            pwrite_d    = 1'b0;
            pselx_d     = decode(Haddr1);
            hreadyout_d = 1'b0;
          end
        end else begin
          hreadyout_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (idle_exit) begin
      penable_d = 1'b0;
      if (valid && !Hwrite) begin
        state_d     = ST_READ;
        paddr_d     = Haddr;
        pwrite_d    = 1'b0;
        pselx_d     = decode(Haddr);
        hreadyout_d = 1'b0;
      end else begin
        state_d     = valid ? ST_WWAIT : ST_IDLE;
        pselx_d     = 3'b000;
        hreadyout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= ST_IDLE;
      pselx_q     <= 3'b000;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hreadyout_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hreadyout_q <= hreadyout_d;
    end
  end

  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: directed AHB beats with per-cycle handshake
// checks and a scoreboard of expected APB transfers.
module tb_apb_fsm_controller;

  logic        Hclk;
  logic        Hreset;
  logic        valid;
  logic        Hwrite;
  logic        Hwritereg;
  logic [31:0] Haddr;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hwdata;
  logic [31:0] Hwdata1;
  logic        Pready;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  apb_fsm_controller dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .valid     (valid),
    .Hwrite    (Hwrite),
    .Hwritereg (Hwritereg),
    .Haddr     (Haddr),
    .Haddr1    (Haddr1),
    .Haddr2    (Haddr2),
    .Hwdata    (Hwdata),
    .Hwdata1   (Hwdata1),
    .Pready    (Pready),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Hreadyout (Hreadyout)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // One bus cycle: wait for the edge, advance the AHB slave pipeline registers,
  // then present the next cycle's inputs.
  task automatic applyStimulus(input logic rst, input logic v, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic rdy);
    @(posedge Hclk);
    #1;
    Haddr2    = Haddr1;
    Haddr1    = Haddr;
    Hwritereg = Hwrite;
    Hwdata1   = Hwdata;
    Hreset    = rst;
    valid     = v;
    Hwrite    = w;
    Haddr     = a;
    Hwdata    = d;
    Pready    = rdy;
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] sel,
                             input logic en, input logic hr);
    checks++;
    if ({Pselx, Penable, Hreadyout} !== {sel, en, hr}) begin
      errors++;
      $display("[TB] FAIL %s: got sel=%b en=%b hr=%b, expected sel=%b en=%b hr=%b",
               name, Pselx, Penable, Hreadyout, sel, en, hr);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectTransfer(input logic [2:0] sel, input logic [31:0] addr,
                                input logic wr, input logic [31:0] data);
    xfer_t x;
    x.sel  = sel;
    x.addr = addr;
    x.wr   = wr;
    x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic singleRead(input string name, input logic [31:0] addr,
                            input logic [2:0] sel);
    expectTransfer(sel, addr, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b1);
    idleCycle(1'b1);
    checkOutput({name, "_setup"}, sel, 1'b0, 1'b0);
    checkValue({name, "_pwrite"}, {31'b0, Pwrite}, 32'h0);
    idleCycle(1'b1);
    checkOutput({name, "_enable"}, sel, 1'b1, 1'b1);
    idleCycle(1'b1);
    checkOutput({name, "_done"}, 3'b000, 1'b0, 1'b1);
  endtask

  // A transfer completes on any cycle with Penable and Pready both high.
  always @(negedge Hclk) begin
    if (!Hreset && Penable && Pready) begin
      xfer_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_xfer: got sel=%b addr=0x%08h wr=%b, expected no transfer",
                 Pselx, Paddr, Pwrite);
      end else begin
        e = exp_q.pop_front();
        if (Pselx !== e.sel || Paddr !== e.addr || Pwrite !== e.wr ||
            (e.wr && Pwdata !== e.data)) begin
          errors++;
          $display("[TB] FAIL xfer: got sel=%b addr=0x%08h wr=%b data=0x%08h, expected sel=%b addr=0x%08h wr=%b data=0x%08h",
                   Pselx, Paddr, Pwrite, Pwdata, e.sel, e.addr, e.wr, e.data);
        end
      end
    end
  end

  initial begin
    Hreset = 1'b1; valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0;
    Haddr = '0; Haddr1 = '0; Haddr2 = '0; Hwdata = '0; Hwdata1 = '0;
    Pready = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("reset", 3'b000, 1'b0, 1'b1);
    checkValue("reset_paddr", Paddr, 32'h0);
    checkValue("reset_pwdata", Pwdata, 32'h0);
    checkValue("reset_pwrite", {31'b0, Pwrite}, 32'h0);
    idleCycle(1'b1);

    $display("[TB] single read");
    singleRead("rd0", 32'h8000_0010, 3'b001);

    $display("[TB] single write");
    expectTransfer(3'b010, 32'h8400_0004, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8400_0004, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    checkOutput("wr_wwait", 3'b000, 1'b0, 1'b1);
    idleCycle(1'b1);
    checkOutput("wr_setup", 3'b010, 1'b0, 1'b1);
    checkValue("wr_pwdata", Pwdata, 32'hDEAD_BEEF);
    idleCycle(1'b1);
    checkOutput("wr_enable", 3'b010, 1'b1, 1'b1);
    idleCycle(1'b1);
    checkOutput("wr_done", 3'b000, 1'b0, 1'b1);

    $display("[TB] back-to-back writes");
    expectTransfer(3'b100, 32'h8800_0000, 1'b1, 32'h11);
    expectTransfer(3'b100, 32'h8800_0004, 1'b1, 32'h22);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8800_0000, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8800_0004, 32'h11, 1'b1);
    checkOutput("b2b_wwait", 3'b000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8800_0004, 32'h22, 1'b1);
    checkOutput("b2b_writep", 3'b100, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h22, 1'b1);
    checkOutput("b2b_wenablep", 3'b100, 1'b1, 1'b0);
    idleCycle(1'b1);
    checkOutput("b2b_write2", 3'b100, 1'b0, 1'b1);
    checkValue("b2b_paddr2", Paddr, 32'h8800_0004);
    idleCycle(1'b1);
    checkOutput("b2b_wenable2", 3'b100, 1'b1, 1'b1);
    idleCycle(1'b1);
    checkOutput("b2b_done", 3'b000, 1'b0, 1'b1);

    $display("[TB] write then read");
    expectTransfer(3'b001, 32'h8000_0100, 1'b1, 32'hA5A5_0001);
    expectTransfer(3'b010, 32'h8400_0020, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0100, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h8400_0020, 32'hA5A5_0001, 1'b1);
    checkOutput("wr_rd_wwait", 3'b000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h8400_0020, 32'h0, 1'b1);
    checkOutput("wr_rd_writep", 3'b001, 1'b0, 1'b0);
    idleCycle(1'b1);
    checkOutput("wr_rd_wenablep", 3'b001, 1'b1, 1'b0);
    idleCycle(1'b1);
    checkOutput("wr_rd_read", 3'b010, 1'b0, 1'b0);
    checkValue("wr_rd_pwrite", {31'b0, Pwrite}, 32'h0);
    checkValue("wr_rd_paddr", Paddr, 32'h8400_0020);
    idleCycle(1'b1);
    checkOutput("wr_rd_renable", 3'b010, 1'b1, 1'b1);
    idleCycle(1'b1);
    checkOutput("wr_rd_done", 3'b000, 1'b0, 1'b1);

    $display("[TB] read with wait states");
    expectTransfer(3'b100, 32'h8800_0008, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h8800_0008, 32'h0, 1'b1);
    idleCycle(1'b0);
    checkOutput("ws_setup", 3'b100, 1'b0, 1'b0);
    idleCycle(1'b0);
    checkOutput("ws_enable", 3'b100, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idleCycle(i == 2 ? 1'b1 : 1'b0);
      checkOutput($sformatf("ws_wait%0d", i), 3'b100, 1'b1, 1'b0);
      checkValue($sformatf("ws_paddr%0d", i), Paddr, 32'h8800_0008);
    end
    idleCycle(1'b1);
    checkOutput("ws_done", 3'b000, 1'b0, 1'b1);

    $display("[TB] reset during write enable");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0040, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_1234, 1'b1);
    idleCycle(1'b1);
    checkOutput("rst_setup", 3'b001, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("rst_enable", 3'b001, 1'b1, 1'b1);
    idleCycle(1'b1);
    checkOutput("rst_after", 3'b000, 1'b0, 1'b1);
    checkValue("rst_paddr", Paddr, 32'h0);
    checkValue("rst_pwdata", Pwdata, 32'h0);
    checkValue("rst_pwrite", {31'b0, Pwrite}, 32'h0);

    $display("[TB] decode boundaries");
    singleRead("rd_unmapped_hi", 32'h8C00_0000, 3'b000);
    singleRead("rd_unmapped_lo", 32'h7FFF_FFFC, 3'b000);
    singleRead("rd_slv1_top", 32'h87FF_FFFC, 3'b010);
    singleRead("rd_slv2_top", 32'h8BFF_FFFC, 3'b100);

    idleCycle(1'b1);
    idleCycle(1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d transfers outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
